// File: rtl/layer_acc_blk_if.sv
// Engine-result and output-stream bundle for layer_acc_blk.
// The master side is the sequencer; the slave side is the engine plus output sink.
interface layer_acc_blk_if #(
    parameter int unsigned NPIX      = 4,
    parameter int unsigned OUT_FM_CH = 2,
    parameter int unsigned DW        = 16,
    parameter int unsigned ACC_W     = 32
);
    localparam int unsigned PA_W = $clog2(NPIX) + 1;

    logic                       i_pe_valid;
    logic [ACC_W*OUT_FM_CH-1:0] i_pe_data;
    logic                       o_out_valid;
    logic [PA_W-1:0]            o_out_addr;
    logic [DW*OUT_FM_CH-1:0]    o_out_data;
    logic                       i_out_ready;

    modport master (
        input  i_pe_valid, i_pe_data, i_out_ready,
        output o_out_valid, o_out_addr, o_out_data
    );

    modport slave (
        output i_pe_valid, i_pe_data, i_out_ready,
        input  o_out_valid, o_out_addr, o_out_data
    );
endinterface

// File: rtl/layer_acc_blk.sv
// Multi-channel convolution layer sequencer: streams weights and feature-map reads per
// input channel, accumulates engine results across channels, drains ReLU'd, saturated words.
module layer_acc_blk #(
    parameter int unsigned KERNEL_SIZE = 3,
    parameter int unsigned FM_WORDS    = 16,
    parameter int unsigned OUT_SIZE    = 2,
    parameter int unsigned IN_FM_CH    = 2,
    parameter int unsigned OUT_FM_CH   = 2,
    parameter int unsigned DW          = 16,
    parameter int unsigned ACC_W       = 32,
    parameter int unsigned SHIFT       = 0,
    parameter int unsigned RELU        = 1,
    localparam int unsigned K2   = KERNEL_SIZE * KERNEL_SIZE,
    localparam int unsigned NPIX = OUT_SIZE * OUT_SIZE,
    localparam int unsigned CH_W = $clog2(IN_FM_CH) + 1,
    localparam int unsigned WA_W = $clog2(K2) + 1,
    localparam int unsigned FA_W = $clog2(FM_WORDS) + 1,
    localparam int unsigned PA_W = $clog2(NPIX) + 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err,
    output logic [CH_W-1:0] o_ch,
    output logic            o_w_rd,
    output logic [WA_W-1:0] o_w_addr,
    output logic            o_w_load,
    output logic            o_fm_rd,
    output logic [FA_W-1:0] o_fm_addr,
    output logic            o_go,
    layer_acc_blk_if.master bus
);
    localparam int unsigned PI_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int unsigned OW   = DW * OUT_FM_CH;
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_STREAM, S_NEXT, S_DRAIN, S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic            w_rd_q, w_rd_d, w_load_q, w_load_d;
    logic [WA_W-1:0] w_addr_q, w_addr_d;
    logic            fm_rd_q, fm_rd_d, go_q, go_d, fm_issued_q, fm_issued_d;
    logic [FA_W-1:0] fm_addr_q, fm_addr_d;
    logic [PA_W-1:0] res_cnt_q, res_cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [PA_W-1:0] out_addr_q, out_addr_d;
    logic [OW-1:0]   out_data_q, out_data_d;
    logic [ACC_W-1:0] acc_q [NPIX][OUT_FM_CH];
    logic [ACC_W-1:0] acc_d [NPIX][OUT_FM_CH];

    logic fm_last, fm_all, res_take, res_all;

    assign fm_last  = fm_rd_q && (fm_addr_q == FA_W'(FM_WORDS - 1));
    assign fm_all   = fm_issued_q || fm_last;
    assign res_take = (state_q == S_STREAM) && bus.i_pe_valid && (res_cnt_q != PA_W'(NPIX));
    assign res_all  = (res_cnt_q == PA_W'(NPIX)) || (res_take && (res_cnt_q == PA_W'(NPIX - 1)));

    // ReLU, arithmetic shift, then clamp to the signed DW range.
    function automatic logic [DW-1:0] sat_word(input logic [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] v;
        logic signed [ACC_W-1:0] s;
        v = a;
        if ((RELU != 0) && (v < 0)) v = '0;
        s = v >>> SHIFT;
        if (s > SAT_MAX)      return SAT_MAX[DW-1:0];
        else if (s < SAT_MIN) return SAT_MIN[DW-1:0];
        else                  return s[DW-1:0];
    endfunction

    function automatic logic [OW-1:0] pack_pix(input logic [PI_W-1:0] p);
        logic [OW-1:0] w;
        w = '0;
        for (int j = 0; j < OUT_FM_CH; j++) w[j*DW +: DW] = sat_word(acc_q[p][j]);
        return w;
    endfunction

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        w_rd_d      = w_rd_q;
        w_addr_d    = w_addr_q;
        fm_rd_d     = fm_rd_q;
        fm_addr_d   = fm_addr_q;
        fm_issued_d = fm_issued_q;
        res_cnt_d   = res_cnt_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        acc_d       = acc_q;
        w_load_d    = w_rd_q;
        go_d        = fm_rd_q;
        err_d       = err_q || (bus.i_pe_valid && !res_take);

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d  = S_LOAD_W;
                    ch_d     = '0;
                    w_rd_d   = 1'b1;
                    w_addr_d = '0;
                end
            end
            S_LOAD_W: begin
                if (w_addr_q == WA_W'(K2 - 1)) begin
                    state_d   = S_STREAM;
                    w_rd_d    = 1'b0;
                    fm_rd_d   = 1'b1;
                    fm_addr_d = '0;
                end else begin
                    w_addr_d = w_addr_q + WA_W'(1);
                end
            end
            S_STREAM: begin
                if (fm_last) begin
                    fm_rd_d     = 1'b0;
                    fm_issued_d = 1'b1;
                end else if (fm_rd_q) begin
                    fm_addr_d = fm_addr_q + FA_W'(1);
                end
                // Channel 0 overwrites, so no clear pass is needed between layers.
                if (res_take) begin
                    for (int j = 0; j < OUT_FM_CH; j++) begin
                        if (ch_q == '0)
                            acc_d[res_cnt_q[PI_W-1:0]][j] = bus.i_pe_data[j*ACC_W +: ACC_W];
                        else
                            acc_d[res_cnt_q[PI_W-1:0]][j] = acc_q[res_cnt_q[PI_W-1:0]][j]
                                                          + bus.i_pe_data[j*ACC_W +: ACC_W];
                    end
                    res_cnt_d = res_cnt_q + PA_W'(1);
                end
                if (fm_all && res_all) state_d = S_NEXT;
            end
            S_NEXT: begin
                ch_d        = ch_q + CH_W'(1);
                res_cnt_d   = '0;
                fm_issued_d = 1'b0;
                if (ch_q == CH_W'(IN_FM_CH - 1)) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d  = S_LOAD_W;
                    w_rd_d   = 1'b1;
                    w_addr_d = '0;
                end
            end
            S_DRAIN: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_addr_d  = '0;
                    out_data_d  = pack_pix('0);
                end else if (bus.i_out_ready) begin
                    if (out_addr_q == PA_W'(NPIX - 1)) begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b0;
                    end else begin
                        out_addr_d = out_addr_q + PA_W'(1);
                        out_data_d = pack_pix(PI_W'(out_addr_q + PA_W'(1)));
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_LOAD_W) || (state_d == S_STREAM) ||
                 (state_d == S_NEXT)   || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ch_q        <= '0;
            w_rd_q      <= 1'b0;
            w_addr_q    <= '0;
            w_load_q    <= 1'b0;
            fm_rd_q     <= 1'b0;
            fm_addr_q   <= '0;
            go_q        <= 1'b0;
            fm_issued_q <= 1'b0;
            res_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ch_q        <= ch_d;
            w_rd_q      <= w_rd_d;
            w_addr_q    <= w_addr_d;
            w_load_q    <= w_load_d;
            fm_rd_q     <= fm_rd_d;
            fm_addr_q   <= fm_addr_d;
            go_q        <= go_d;
            fm_issued_q <= fm_issued_d;
            res_cnt_q   <= res_cnt_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
        end
    end

    // Accumulator is intentionally unreset; channel 0 always rewrites every pixel.
    always_ff @(posedge i_clk) begin
        acc_q <= acc_d;
    end

    assign o_busy          = busy_q;
    assign o_done          = done_q;
    assign o_err           = err_q;
    assign o_ch            = ch_q;
    assign o_w_rd          = w_rd_q;
    assign o_w_addr        = w_addr_q;
    assign o_w_load        = w_load_q;
    assign o_fm_rd         = fm_rd_q;
    assign o_fm_addr       = fm_addr_q;
    assign o_go            = go_q;
    assign bus.o_out_valid = out_valid_q;
    assign bus.o_out_addr  = out_addr_q;
    assign bus.o_out_data  = out_data_q;
endmodule

// File: tb/tb_layer_acc_blk.sv
// Directed bench for layer_acc_blk: three instances (RELU=1/SHIFT=0, RELU=0/SHIFT=0,
// RELU=0/SHIFT=2) share one stimulus stream and are checked against hand-computed words.
module tb_layer_acc_blk;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic pe_valid = 1'b0;
    logic [63:0] pe_data = '0;
    logic out_ready = 1'b1;

    logic [2:0] busy, done, err, w_rd, w_load, fm_rd, go;
    logic [1:0] ch [3];
    logic [4:0] w_addr [3];
    logic [4:0] fm_addr [3];

    int checks = 0;
    int errors = 0;
    int s0 [4][2];
    int s1 [4][2];
    int exp_a [4][2];
    int exp_b [4][2];
    int exp_c [4][2];

    always #5 clk = ~clk;

    layer_acc_blk_if #(.NPIX(4), .OUT_FM_CH(2), .DW(16), .ACC_W(32)) bus_a ();
    layer_acc_blk_if #(.NPIX(4), .OUT_FM_CH(2), .DW(16), .ACC_W(32)) bus_b ();
    layer_acc_blk_if #(.NPIX(4), .OUT_FM_CH(2), .DW(16), .ACC_W(32)) bus_c ();

    assign bus_a.i_pe_valid = pe_valid;  assign bus_a.i_pe_data = pe_data;  assign bus_a.i_out_ready = out_ready;
    assign bus_b.i_pe_valid = pe_valid;  assign bus_b.i_pe_data = pe_data;  assign bus_b.i_out_ready = out_ready;
    assign bus_c.i_pe_valid = pe_valid;  assign bus_c.i_pe_data = pe_data;  assign bus_c.i_out_ready = out_ready;

    layer_acc_blk #(.RELU(1), .SHIFT(0)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_busy(busy[0]), .o_done(done[0]),
        .o_err(err[0]), .o_ch(ch[0]), .o_w_rd(w_rd[0]), .o_w_addr(w_addr[0]), .o_w_load(w_load[0]),
        .o_fm_rd(fm_rd[0]), .o_fm_addr(fm_addr[0]), .o_go(go[0]), .bus(bus_a));
    layer_acc_blk #(.RELU(0), .SHIFT(0)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_busy(busy[1]), .o_done(done[1]),
        .o_err(err[1]), .o_ch(ch[1]), .o_w_rd(w_rd[1]), .o_w_addr(w_addr[1]), .o_w_load(w_load[1]),
        .o_fm_rd(fm_rd[1]), .o_fm_addr(fm_addr[1]), .o_go(go[1]), .bus(bus_b));
    layer_acc_blk #(.RELU(0), .SHIFT(2)) dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_busy(busy[2]), .o_done(done[2]),
        .o_err(err[2]), .o_ch(ch[2]), .o_w_rd(w_rd[2]), .o_w_addr(w_addr[2]), .o_w_load(w_load[2]),
        .o_fm_rd(fm_rd[2]), .o_fm_addr(fm_addr[2]), .o_go(go[2]), .bus(bus_c));

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int w16(input logic [15:0] x);
        return int'($signed(x));
    endfunction

    task automatic wait_fm(input logic lvl, input string tag);
        int n = 0;
        while (fm_rd[0] !== lvl && n < 200) begin step(); n++; end
        chk(tag, int'(n < 200), 1);
    endtask

    task automatic send(input int c, input int p);
        pe_valid = 1'b1;
        pe_data  = (c == 0) ? {s0[p][1], s0[p][0]} : {s1[p][1], s1[p][0]};
        step();
        pe_valid = 1'b0;
    endtask

    task automatic uniform(input int v0, input int v1, input int ea, input int eb, input int ec);
        for (int p = 0; p < 4; p++)
            for (int j = 0; j < 2; j++) begin
                s0[p][j] = v0; s1[p][j] = v1;
                exp_a[p][j] = ea; exp_b[p][j] = eb; exp_c[p][j] = ec;
            end
    endtask

    task automatic set_pix(input int p, input int j, input int sum, input int ea, input int eb, input int ec);
        s0[p][j] = sum + 5; s1[p][j] = -5;
        exp_a[p][j] = ea; exp_b[p][j] = eb; exp_c[p][j] = ec;
    endtask

    task automatic zero_check(input string tag);
        chk({tag, "_busy"}, busy[0], 0);       chk({tag, "_done"}, done[0], 0);
        chk({tag, "_err"}, err[0], 0);         chk({tag, "_ch"}, ch[0], 0);
        chk({tag, "_w_rd"}, w_rd[0], 0);       chk({tag, "_w_addr"}, w_addr[0], 0);
        chk({tag, "_w_load"}, w_load[0], 0);   chk({tag, "_fm_rd"}, fm_rd[0], 0);
        chk({tag, "_fm_addr"}, fm_addr[0], 0); chk({tag, "_go"}, go[0], 0);
        chk({tag, "_ovalid"}, bus_a.o_out_valid, 0);
        chk({tag, "_oaddr"}, bus_a.o_out_addr, 0);
        chk({tag, "_odata"}, bus_a.o_out_data, 0);
    endtask

    task automatic chk_word(input string tag, input int p);
        for (int j = 0; j < 2; j++) begin
            chk($sformatf("%s_a_p%0d_c%0d", tag, p, j), w16(bus_a.o_out_data[j*16 +: 16]), exp_a[p][j]);
            chk($sformatf("%s_b_p%0d_c%0d", tag, p, j), w16(bus_b.o_out_data[j*16 +: 16]), exp_b[p][j]);
            chk($sformatf("%s_c_p%0d_c%0d", tag, p, j), w16(bus_c.o_out_data[j*16 +: 16]), exp_c[p][j]);
        end
    endtask

    // One full layer; late=1 sends results after the FM addresses finish.
    task automatic do_layer(input string tag, input int late, input int stall_en,
                            input int inject, input int start_in_drain, input int detail);
        int k = 0, cyc = 0, stall = 0, n = 0, extra = 0, sd = 0;
        chk({tag, "_idle_busy"}, busy[0], 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_busy_rise"}, busy[0], 1);
        if (detail != 0) begin
            chk({tag, "_w_rd0"}, w_rd[0], 1);
            chk({tag, "_w_addr0"}, w_addr[0], 0);
            chk({tag, "_w_load0"}, w_load[0], 0);
            step();
            chk({tag, "_w_load1"}, w_load[0], 1);
            chk({tag, "_w_addr1"}, w_addr[0], 1);
        end
        if (inject != 0) begin
            chk({tag, "_err_pre"}, err[0], 0);
            pe_valid = 1'b1;
            pe_data  = {32'd999, 32'd999};
            step();
            pe_valid = 1'b0;
            chk({tag, "_err_set"}, err[0], 1);
        end
        for (int c = 0; c < 2; c++) begin
            wait_fm(1'b1, $sformatf("%s_tmo_fm_on%0d", tag, c));
            chk($sformatf("%s_ch%0d", tag, c), ch[0], c);
            chk($sformatf("%s_fm_addr0_%0d", tag, c), fm_addr[0], 0);
            if (detail != 0) chk({tag, "_go_lag"}, go[0], 0);
            if (late != 0) begin
                wait_fm(1'b0, $sformatf("%s_tmo_fm_off%0d", tag, c));
                for (int p = 0; p < 4; p++) send(c, p);
            end else begin
                for (int p = 0; p < 4; p++) send(c, p);
                if (detail != 0) begin
                    chk({tag, "_fm_addr4"}, fm_addr[0], 4);
                    chk({tag, "_go_on"}, go[0], 1);
                end
                wait_fm(1'b0, $sformatf("%s_tmo_fm_end%0d", tag, c));
            end
        end
        while (bus_a.o_out_valid !== 1'b1 && n < 50) begin step(); n++; end
        chk({tag, "_tmo_valid"}, int'(n < 50), 1);
        while (k < 4 && cyc < 50) begin
            out_ready = !(stall_en != 0 && k == 1 && stall < 3);
            start = (start_in_drain != 0 && k == 2 && sd == 0);
            if (start) sd = 1;
            cyc++;
            chk($sformatf("%s_addr_k%0d", tag, k), bus_a.o_out_addr, k);
            chk_word(tag, k);
            if (out_ready) k++;
            else stall++;
            if (done[0]) extra++;
            step();
        end
        out_ready = 1'b1;
        start = 1'b0;
        chk({tag, "_drain_cycles"}, cyc, (stall_en != 0) ? 7 : 4);
        chk({tag, "_done_pulse"}, done[0], 1);
        chk({tag, "_done_busy"}, busy[0], 0);
        chk({tag, "_done_valid"}, bus_a.o_out_valid, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            if (done[0]) extra++;
        end
        chk({tag, "_done_once"}, extra, 0);
        chk({tag, "_busy_after"}, busy[0], 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        zero_check("rst0");
        rst_n = 1'b1;
        step();

        uniform(100, -30, 70, 70, 17);
        do_layer("basic", 0, 0, 0, 0, 1);
        chk("basic_err", err[0], 0);

        set_pix(0, 0, -50,    0,     -50,    -13);
        set_pix(0, 1, 40000,  32767, 32767,  10000);
        set_pix(1, 0, -40000, 0,     -32768, -10000);
        set_pix(1, 1, 103,    103,   103,    25);
        set_pix(2, 0, -9,     0,     -9,     -3);
        set_pix(2, 1, 0,      0,     0,      0);
        set_pix(3, 0, 32767,  32767, 32767,  8191);
        set_pix(3, 1, -32768, 0,     -32768, -8192);
        do_layer("sat_late_bp", 1, 1, 0, 0, 0);
        do_layer("sat_early", 0, 0, 0, 0, 0);
        chk("sat_err", err[0], 0);

        uniform(-20, 50, 30, 30, 7);
        do_layer("err_inj", 0, 0, 1, 0, 0);
        chk("err_sticky", err[0], 1);

        start = 1'b1;
        step();
        start = 1'b0;
        wait_fm(1'b1, "rst_tmo_fm");
        send(0, 0);
        step();
        rst_n = 1'b0;
        #1;
        zero_check("rst_mid");
        step();
        rst_n = 1'b1;
        step();

        uniform(7, 5, 12, 12, 3);
        do_layer("after_rst", 1, 0, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
